func_sweep_ctrl: RTL
====================

# func_sweep_ctrl

Sequencer that exhaustively drives the input vector of a 4-input combinational function block (A,B,C,D → f), samples f for every combination, and checks it against an expected truth-table mask. It sits beside the function block and replaces the hand-written `#5` stimulus sweep with a clocked, self-checking run. Software or a top-level FSM pulses `start`, waits for `done`, and reads `pass` and `captured`.

## Interface
Parameters:
- N_IN, 4, number of function inputs; vectors swept = 2**N_IN.
- SETTLE, 1, wait cycles after each vector change before f is sampled (0..15).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  run request, sampled in IDLE only.
- expected  in  2**N_IN  expected f per index; bit i = f for vector i.
- vec_out  out  N_IN  registered vector to the function block; MSB = A, LSB = D.
- f_in  in  1  function output.
- busy  out  1  high from the accepted start through the final sample.
- done  out  1  one-cycle pulse at run end.
- pass  out  1  captured == expected of the last run; held until the next start.
- captured  out  2**N_IN  observed truth table of the last run.
- err_count  out  N_IN+1  mismatches in the last run (MISMATCH_LOG_EN only).
- first_err_idx  out  N_IN  lowest mismatching index (MISMATCH_LOG_EN only).

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: `start`=1 → latch `expected` into exp_q, clear `captured`/`pass`/log, idx=0, vec_out=0, busy=1, settle count = SETTLE. Go to SETTLE, or to SAMPLE if SETTLE=0.
- SETTLE: decrement the counter each cycle. At 0 → SAMPLE.
- SAMPLE: one cycle; at its closing edge captured[idx] ← f_in. If idx == 2**N_IN−1 → DONE; otherwise idx+1, vec_out ← idx+1, reload the counter, → SETTLE (or stay in SAMPLE if SETTLE=0).
- DONE: done=1, busy=0, pass = (captured == exp_q), computed on the final captured value including the last sample. Next cycle → IDLE.
- `start` while not in IDLE is ignored; no queuing. `start` held high re-arms a new run the cycle after DONE.
- `expected` changes mid-run have no effect (latched copy used).
- Index wrap: idx never wraps; the run terminates at 2**N_IN−1.

## Timing
- Reset values: vec_out=0, busy=0, done=0, pass=0, captured=0, err_count=0, first_err_idx=0, state IDLE.
- Reset mid-run aborts immediately and drives all outputs to reset values. No done pulse.
- start accepted at edge E0 → vector k presented from E0+k·(SETTLE+1). f sampled at edge E0+(k+1)·(SETTLE+1).
- done high for the cycle after edge E0+2**N_IN·(SETTLE+1). `pass`/`captured` are valid from that same cycle.
- Run length for defaults: 32 cycles busy, then 1 cycle done.
- f_in must be stable SETTLE+1 cycles after vec_out changes; combinational delay beyond that is a system error, not handled.

## Configuration
- Macro FUNC_SWEEP_MISMATCH_LOG_EN.
- Defined: err_count increments (saturating at 2**N_IN) on each sample where f_in != exp_q[idx]. first_err_idx records the first such idx and is held for the run. Both are cleared on start.
- Undefined: the err_count and first_err_idx ports and logic are absent. Only pass/captured are reported.

## Test plan
- Reset, then start with expected=16'h87B6, SETTLE=1, function block connected → vec_out steps 0..15, every 2 cycles; done 33 cycles after start; pass=1; captured=16'h87B6; err_count=0.
- Same run with expected=16'h87B7 → pass=0; captured=16'h87B6; err_count=1; first_err_idx=0.
- f_in stuck at 0, expected=16'h87B6 → pass=0; captured=0; err_count=9; first_err_idx=1.
- Pulse start again at cycle 10 of a run, and change expected mid-run → second start ignored; result matches the originally latched expected; exactly one done pulse.
- Deassert rst_n at cycle 12 of a run → vec_out=0, busy=0, captured=0 asynchronously. After release, a new start runs cleanly to pass=1.
- SETTLE=0 → one vector per cycle; done 17 cycles after start; captured=16'h87B6.

Source files
------------

// File: rtl/func_sweep_ctrl.sv
// Clocked exhaustive sweep of an N_IN-input function block, capturing its truth table and comparing it to an expected mask.
// Optional mismatch logging (err_count / first_err_idx) is enabled by defining FUNC_SWEEP_MISMATCH_LOG_EN.
module func_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [2**N_IN-1:0]   i_expected,
  output logic [N_IN-1:0]      o_vec_out,
  input  logic                 i_f_in,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [2**N_IN-1:0]   o_captured
`ifdef FUNC_SWEEP_MISMATCH_LOG_EN
  ,
  output logic [N_IN:0]        o_err_count,
  output logic [N_IN-1:0]      o_first_err_idx
`endif
);

  localparam int              NV        = 2**N_IN;
  localparam int              CW        = 4;
  localparam logic [CW-1:0]   SETTLE_C  = CW'(SETTLE);
  localparam logic [N_IN-1:0] LAST_IDX  = N_IN'(NV - 1);
  localparam bit              NO_SETTLE = (SETTLE == 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [NV-1:0]   r_exp;
  logic [NV-1:0]   r_cap;
  logic [NV-1:0]   w_cap_nxt;
  logic [N_IN-1:0] r_vec;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic            w_accept;
  logic            w_sample;
  logic            w_last;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; the counter leaves SETTLE on its last count so each vector occupies SETTLE+1 cycles
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_last      = (r_vec == LAST_IDX);
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = NO_SETTLE ? S_SAMPLE : S_SETTLE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt <= CW'(1)) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_state_nxt = S_SETTLE;
        end
      end
      S_SAMPLE: begin
        w_sample = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = NO_SETTLE ? S_SAMPLE : S_SETTLE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Truth table including the sample being taken this cycle, so pass covers the final bit
  always_comb begin
    w_cap_nxt        = r_cap;
    w_cap_nxt[r_vec] = i_f_in;
  end

  // Run datapath: vector index, settle counter, capture, verdict
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_exp  <= '0;
      r_cap  <= '0;
      r_vec  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_done <= w_sample & w_last;
      if (w_accept) begin
        r_exp  <= i_expected;
        r_cap  <= '0;
        r_pass <= 1'b0;
        r_vec  <= '0;
        r_busy <= 1'b1;
        r_cnt  <= SETTLE_C;
      end else if (w_sample) begin
        r_cap <= w_cap_nxt;
        if (w_last) begin
          r_busy <= 1'b0;
          r_pass <= (w_cap_nxt == r_exp);
        end else begin
          r_vec <= r_vec + N_IN'(1);
          r_cnt <= SETTLE_C;
        end
      end else if (r_state == S_SETTLE) begin
        r_cnt <= r_cnt - CW'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

`ifdef FUNC_SWEEP_MISMATCH_LOG_EN
  logic [N_IN:0]   r_err;
  logic [N_IN-1:0] r_first;

  // Mismatch log; indices are swept upward so the first recorded mismatch is the lowest
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err   <= '0;
      r_first <= '0;
    end else if (w_accept) begin
      r_err   <= '0;
      r_first <= '0;
    end else if (w_sample && (i_f_in != r_exp[r_vec])) begin
      if (r_err != (N_IN+1)'(NV)) begin
        r_err <= r_err + (N_IN+1)'(1);
      end else begin
        r_err <= r_err;
      end
      if (r_err == '0) begin
        r_first <= r_vec;
      end else begin
        r_first <= r_first;
      end
    end else begin
      r_err   <= r_err;
      r_first <= r_first;
    end
  end

  assign o_err_count     = r_err;
  assign o_first_err_idx = r_first;
`endif

  assign o_vec_out  = r_vec;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_pass     = r_pass;
  assign o_captured = r_cap;

endmodule
